// File: rtl/bus_master_ctrl_pkg.sv
// Shared definitions for the bus master sequencer: bus widths, polarity
// constants, FSM state encoding and the default strobe timeout.
package bus_master_ctrl_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int unsigned BUS_MCTRL_TIMEOUT_DEF = 255;
  localparam int          BUS_MCTRL_CNT_W       = 8;

  typedef enum logic [1:0] {
    BUS_MCTRL_IDLE   = 2'd0,
    BUS_MCTRL_REQ    = 2'd1,
    BUS_MCTRL_ACCESS = 2'd2
  } bus_mctrl_state_e;

endpackage

// File: rtl/bus_master_ctrl.sv
// Master-side bus sequencer: turns one client request into a full
// request/grant/strobe/ready bus cycle and reports data, done and error.
// Every output is a register; the comb process computes next values.
module bus_master_ctrl
  import bus_master_ctrl_pkg::*;
#(
  // Strobe cycles without ready before an error completion; 0 disables.
  parameter int unsigned TIMEOUT = BUS_MCTRL_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   c_req,
  input  logic [WORD_ADDR_W-1:0] c_addr,
  input  logic                   c_rw,
  input  logic [WORD_DATA_W-1:0] c_wr_data,
  output logic                   c_busy,
  output logic                   c_done,
  output logic                   c_err,
  output logic [WORD_DATA_W-1:0] c_rd_data,
  output logic                   bus_req_,
  input  logic                   bus_grnt_,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic                   bus_as_,
  output logic                   bus_rw,
  output logic [WORD_DATA_W-1:0] bus_wr_data,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy_
);

  localparam logic                       TO_EN   = (TIMEOUT != 0);
  // Counter value seen on the TIMEOUT-th strobe cycle (counter starts at 0).
  localparam logic [BUS_MCTRL_CNT_W-1:0] TO_LAST = BUS_MCTRL_CNT_W'(TIMEOUT - 1);
  localparam logic [BUS_MCTRL_CNT_W-1:0] CNT_MAX = '1;

  bus_mctrl_state_e            state, state_nxt;
  logic [BUS_MCTRL_CNT_W-1:0]  cnt, cnt_nxt;
  logic                        c_busy_nxt, c_done_nxt, c_err_nxt;
  logic [WORD_DATA_W-1:0]      c_rd_data_nxt;
  logic                        bus_req_nxt, bus_as_nxt, bus_rw_nxt;
  logic [WORD_ADDR_W-1:0]      bus_addr_nxt;
  logic [WORD_DATA_W-1:0]      bus_wr_data_nxt;

  // State, counter and all outputs registered; sync reset to idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BUS_MCTRL_IDLE;
      cnt         <= '0;
      c_busy      <= 1'b0;
      c_done      <= 1'b0;
      c_err       <= 1'b0;
      c_rd_data   <= '0;
      bus_req_    <= DISABLE_;
      bus_as_     <= DISABLE_;
      bus_rw      <= READ;
      bus_addr    <= '0;
      bus_wr_data <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      c_busy      <= c_busy_nxt;
      c_done      <= c_done_nxt;
      c_err       <= c_err_nxt;
      c_rd_data   <= c_rd_data_nxt;
      bus_req_    <= bus_req_nxt;
      bus_as_     <= bus_as_nxt;
      bus_rw      <= bus_rw_nxt;
      bus_addr    <= bus_addr_nxt;
      bus_wr_data <= bus_wr_data_nxt;
    end
  end

  // Next-state and next-output logic; done/err are single-cycle pulses.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    c_busy_nxt      = c_busy;
    c_done_nxt      = 1'b0;
    c_err_nxt       = 1'b0;
    c_rd_data_nxt   = c_rd_data;
    bus_req_nxt     = bus_req_;
    bus_as_nxt      = bus_as_;
    bus_rw_nxt      = bus_rw;
    bus_addr_nxt    = bus_addr;
    bus_wr_data_nxt = bus_wr_data;

    unique case (state)
      BUS_MCTRL_IDLE: begin
        // The address/data registers double as the request latch.
        if (c_req) begin
          bus_addr_nxt    = c_addr;
          bus_rw_nxt      = c_rw;
          bus_wr_data_nxt = c_wr_data;
          bus_req_nxt     = ENABLE_;
          c_busy_nxt      = 1'b1;
          state_nxt       = BUS_MCTRL_REQ;
        end
      end
      BUS_MCTRL_REQ: begin
        if (bus_grnt_ == ENABLE_) begin
          bus_as_nxt = ENABLE_;
          cnt_nxt    = '0;
          state_nxt  = BUS_MCTRL_ACCESS;
        end
      end
      BUS_MCTRL_ACCESS: begin
        // Grant is not rechecked: the arbiter holds it while we request.
        if (bus_rdy_ == ENABLE_) begin
          if (bus_rw == READ) c_rd_data_nxt = bus_rd_data;
          c_done_nxt  = 1'b1;
          bus_as_nxt  = DISABLE_;
          bus_req_nxt = DISABLE_;
          c_busy_nxt  = 1'b0;
          state_nxt   = BUS_MCTRL_IDLE;
        end else if (TO_EN && cnt == TO_LAST) begin
          c_done_nxt  = 1'b1;
          c_err_nxt   = 1'b1;
          bus_as_nxt  = DISABLE_;
          bus_req_nxt = DISABLE_;
          c_busy_nxt  = 1'b0;
          state_nxt   = BUS_MCTRL_IDLE;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = BUS_MCTRL_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Directed bench for bus_master_ctrl with TIMEOUT=4; the bench plays
// arbiter and slave by scripting grant/ready cycle by cycle.
module tb_bus_master_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req;
  logic [29:0] c_addr;
  logic        c_rw;
  logic [31:0] c_wr_data;
  logic        c_busy, c_done, c_err;
  logic [31:0] c_rd_data;
  logic        bus_req_;
  logic        bus_grnt_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;

  int n_tests = 0;
  int n_fail  = 0;

  bus_master_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_addr(c_addr), .c_rw(c_rw), .c_wr_data(c_wr_data),
    .c_busy(c_busy), .c_done(c_done), .c_err(c_err), .c_rd_data(c_rd_data),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
    .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int as_lo, dn, hi, hi_run, req_lo;
    rst = 1'b1; c_req = 1'b0; c_addr = '0; c_rw = 1'b1; c_wr_data = '0;
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_req_", {31'd0, bus_req_}, 32'd1);
    chk("rst_as_",  {31'd0, bus_as_},  32'd1);
    chk("rst_rw",   {31'd0, bus_rw},   32'd1);
    chk("rst_addr", {2'd0, bus_addr},  32'd0);
    chk("rst_wdat", bus_wr_data,       32'd0);
    chk("rst_flags", {29'd0, c_busy, c_done, c_err}, 32'd0);
    chk("rst_rdat", c_rd_data,         32'd0);

    // read, zero wait, grant one cycle after bus_req_
    c_req = 1'b1; c_addr = 30'h0000100; c_rw = 1'b1; c_wr_data = 32'hAAAA5555;
    tick();                                    // t+1
    c_req = 1'b0;
    chk("rd_req_t1", {30'd0, bus_req_, c_busy}, 32'd1);
    chk("rd_as_t1",  {31'd0, bus_as_}, 32'd1);
    tick();                                    // t+2
    bus_grnt_ = 1'b0;
    tick();                                    // t+3
    chk("rd_as_t3",  {31'd0, bus_as_}, 32'd0);
    chk("rd_addr",   {2'd0, bus_addr}, 32'h0000100);
    chk("rd_rw",     {31'd0, bus_rw},  32'd1);
    chk("rd_done_t3", {31'd0, c_done}, 32'd0);
    bus_rdy_ = 1'b0; bus_rd_data = 32'hDEADBEEF;
    tick();                                    // t+4
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    chk("rd_done_t4", {30'd0, c_done, c_err}, 32'd2);
    chk("rd_data",    c_rd_data, 32'hDEADBEEF);
    chk("rd_rel_t4",  {29'd0, bus_as_, bus_req_, c_busy}, 32'd6);
    tick();
    chk("rd_pulse",   {31'd0, c_done}, 32'd0);

    // write with 3 wait states (ready on 4th strobe = TIMEOUT-th, no error)
    c_req = 1'b1; c_addr = 30'h000002A; c_rw = 1'b0; c_wr_data = 32'h12345678;
    bus_rd_data = 32'h55555555;
    tick();
    c_req = 1'b0;
    tick();
    bus_grnt_ = 1'b0;
    tick();                                    // first strobe cycle
    bus_grnt_ = 1'b1;
    as_lo = 0; dn = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus_as_ == 1'b0) as_lo++;
      if (c_done) dn++;
      bus_rdy_ = (k == 3) ? 1'b0 : 1'b1;
      tick();
    end
    bus_rdy_ = 1'b1;
    chk("wr_as_lo",   as_lo, 4);
    chk("wr_early_done", dn, 0);
    chk("wr_done",    {30'd0, c_done, c_err}, 32'd2);
    chk("wr_rw",      {31'd0, bus_rw}, 32'd0);
    chk("wr_wdat",    bus_wr_data, 32'h12345678);
    chk("wr_addr",    {2'd0, bus_addr}, 32'h000002A);
    chk("wr_rdat_kept", c_rd_data, 32'hDEADBEEF);
    chk("wr_as_rel",  {31'd0, bus_as_}, 32'd1);
    tick();
    chk("wr_pulse",   {31'd0, c_done}, 32'd0);

    // grant delayed 10 cycles by a competing master
    c_req = 1'b1; c_addr = 30'h3FFFFFF; c_rw = 1'b1;
    tick();
    c_req = 1'b0;
    as_lo = 0; req_lo = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus_as_ == 1'b0) as_lo++;
      if (bus_req_ == 1'b0) req_lo++;
      tick();
    end
    chk("gd_as_hi",   as_lo, 0);
    chk("gd_req_lo",  req_lo, 10);
    chk("gd_as_pre",  {30'd0, bus_as_, bus_req_}, 32'd2);
    bus_grnt_ = 1'b0;
    tick();
    bus_grnt_ = 1'b1;
    chk("gd_as_post", {30'd0, bus_as_, bus_req_}, 32'd0);
    chk("gd_addr",    {2'd0, bus_addr}, 32'h3FFFFFF);
    bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFEF00D;
    tick();
    bus_rdy_ = 1'b1;
    chk("gd_done",    {30'd0, c_done, c_err}, 32'd2);
    chk("gd_rdat",    c_rd_data, 32'hCAFEF00D);
    tick();

    // timeout: slave never ready, grant dropped during access (ignored)
    c_req = 1'b1; c_addr = 30'h0000777; c_rw = 1'b1;
    bus_rd_data = 32'hBADBAD00;
    tick();
    c_req = 1'b0;
    bus_grnt_ = 1'b0;
    tick();
    bus_grnt_ = 1'b1;
    as_lo = 0; dn = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus_as_ == 1'b0) as_lo++;
      if (c_done) dn++;
      tick();
    end
    chk("to_as_lo",   as_lo, 4);
    chk("to_early_done", dn, 0);
    chk("to_done_err", {30'd0, c_done, c_err}, 32'd3);
    chk("to_rel",     {29'd0, bus_as_, bus_req_, c_busy}, 32'd6);
    chk("to_rdat_kept", c_rd_data, 32'hCAFEF00D);
    tick();
    chk("to_pulse",   {30'd0, c_done, c_err}, 32'd0);

    // back-to-back with c_req held: bus_req_ high exactly one cycle each time
    c_req = 1'b1; c_addr = 30'h0000010; c_rw = 1'b1;
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'h11111111;
    hi = 0; hi_run = 0; dn = 0;
    for (int k = 0; k < 12; k++) begin
      logic prev_hi;
      prev_hi = bus_req_;
      tick();
      if (c_done) dn++;
      if (bus_req_) hi++;
      if (bus_req_ && prev_hi && k > 0) hi_run++;
    end
    chk("b2b_done",   dn, 4);
    chk("b2b_req_hi", hi, 4);
    chk("b2b_hi_run", hi_run, 0);
    c_req = 1'b0;
    tick(); tick(); tick();                    // drain the last started txn
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    tick();
    chk("b2b_idle",   {30'd0, c_busy, bus_req_}, 32'd1);

    // extra c_req pulse while busy is ignored
    dn = 0;
    c_req = 1'b1; c_rw = 1'b0; c_wr_data = 32'h0F0F0F0F;
    tick();
    c_req = 1'b0;
    tick();
    c_req = 1'b1;                              // pulse while in REQ
    tick();
    c_req = 1'b0;
    bus_grnt_ = 1'b0;
    tick();
    bus_grnt_ = 1'b1;
    bus_rdy_ = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      bus_rdy_ = 1'b1;
      if (c_done) dn++;
    end
    chk("busy_req_done", dn, 1);
    chk("busy_req_idle", {30'd0, c_busy, bus_req_}, 32'd1);

    // reset asserted during access
    c_req = 1'b1; c_addr = 30'h0000123; c_rw = 1'b1;
    tick();
    c_req = 1'b0;
    bus_grnt_ = 1'b0;
    tick();
    bus_grnt_ = 1'b1;
    chk("rs_in_access", {31'd0, bus_as_}, 32'd0);
    rst = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'h77777777;
    tick();
    rst = 1'b0; bus_rdy_ = 1'b1;
    chk("rs_rel",  {29'd0, bus_as_, bus_req_, c_busy}, 32'd6);
    chk("rs_done", {30'd0, c_done, c_err}, 32'd0);
    chk("rs_rdat", c_rd_data, 32'd0);
    chk("rs_addr", {2'd0, bus_addr}, 32'd0);
    tick();
    chk("rs_after", {30'd0, c_done, c_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_master_ctrl.md
# bus_master_ctrl

Master-side bus sequencer that turns a simple single-transaction client request into a complete bus cycle on one master port of `bus`. It runs the request/grant handshake with `bus_arbiter`, drives address strobe and write data through `bus_master_mux`, waits for the selected slave's ready, and returns read data, completion and error to the client. One instance per bus master (CPU IF/MEM stages, DMA).

## Interface
- `TIMEOUT`, 255: maximum address-strobe cycles without slave ready before an error completion; 0 disables the timeout.
- `clk`  in  1  system clock
- `rst`  in  1  reset. Synchronous, active-high.
- `c_req`  in  1  client request, sampled only in IDLE
- `c_addr`  in  `WordAddrBus` (30)  client word address
- `c_rw`  in  1  `READ` = 1, `WRITE` = 0
- `c_wr_data`  in  `WordDataBus` (32)  client write data
- `c_busy`  out  1  high while a transaction is in flight (state != IDLE)
- `c_done`  out  1  one-cycle completion pulse
- `c_err`  out  1  high with `c_done` when the transaction timed out
- `c_rd_data`  out  32  read data, valid with `c_done`, held until the next `c_done`
- `bus_req_`  out  1  to arbiter, active-low
- `bus_grnt_`  in  1  from arbiter, active-low
- `bus_addr`  out  30, `bus_as_` out 1 (active-low), `bus_rw` out 1, `bus_wr_data` out 32: to master mux
- `bus_rd_data`  in  32, `bus_rdy_` in 1 (active-low): from slave mux

## Operation
- FSM states: IDLE, REQ, ACCESS. All outputs are registered.
- IDLE: if `c_req`=1, latch `c_addr`/`c_rw`/`c_wr_data`, drive `bus_req_`=0 next cycle, go to REQ.
- REQ: hold `bus_req_`=0. When `bus_grnt_`=0 is sampled, go to ACCESS, drive `bus_as_`=0 with the latched addr/rw/wr_data. The timeout counter clears.
- ACCESS: hold `bus_as_`=0 and `bus_req_`=0. Sample `bus_rdy_` every cycle.
  - `bus_rdy_`=0: capture `bus_rd_data` into `c_rd_data` (read only; writes leave it unchanged), pulse `c_done`, and drive `bus_as_`=1 and `bus_req_`=1 the next cycle. Return to IDLE.
  - `bus_rdy_`=1 for the TIMEOUT-th consecutive strobe cycle: pulse `c_done`+`c_err`, release bus, return to IDLE. `c_rd_data` is unchanged.
- Grant is only checked in REQ. Loss of grant during ACCESS is ignored, because the arbiter keeps the grant while `bus_req_` is held.
- The bus is always released for at least one cycle between transactions, so the arbiter can rotate. There is no locked back-to-back ownership.
- Outside ACCESS, `bus_as_`=1. `bus_addr`, `bus_rw` and `bus_wr_data` keep their last latched values.
- Timeout counter is 8 bits wide, saturating and compared against `TIMEOUT`.

## Timing
- Reset values: `bus_req_`=1, `bus_as_`=1, `bus_rw`=`READ`, `bus_addr`=0, `bus_wr_data`=0, `c_busy`=0, `c_done`=0, `c_err`=0, `c_rd_data`=0. State is IDLE and the counter is 0.
- The sequence is:
  - `c_req` at cycle t
  - `bus_req_` low and `c_busy` high at t+1
  - grant sampled at cycle g
  - `bus_as_` low at g+1
  - rdy_ sampled low at cycle r
  - `c_done` at r+1, with `bus_as_`, `bus_req_` and `c_busy` back high/low at r+1
- Minimum latency: `c_done` at t+4, when the grant arrives at t+2 and the slave is ready in the first strobe cycle.
- `c_req` at r+1 (IDLE again) starts a new transaction: `bus_req_` low again at r+2.
- Simultaneous events:
  - `bus_rdy_`=0 on the timeout cycle is a normal completion, not an error.
  - `c_req` while busy is ignored, not queued.
- Reset mid-transaction returns all outputs to reset values at the next edge. No `c_done` is issued.

## Structure
- `READ`/`WRITE`, `ENABLE_`/`DISABLE_` and the bus widths come from `stddef.vh`/`bus.vh`.
- Add the state encodings (`BUS_MCTRL_IDLE`, `_REQ`, `_ACCESS`) and the default timeout to `bus.vh`.
- Single module, no sub-modules. The timeout counter is inline.

## Test plan
- Read, zero-wait: grant 1 cycle after `bus_req_`, `bus_rdy_`=0 with rd_data 0xDEADBEEF in the first strobe cycle, addr 0x0000100 → `bus_addr`=0x0000100, `c_done` at t+4, `c_rd_data`=0xDEADBEEF, `c_err`=0.
- Write with 3 wait states, wr_data 0x12345678 → `bus_as_` low for 4 cycles, `bus_rw`=0, `c_done` once, `c_rd_data` unchanged.
- Grant delayed 10 cycles by a competing master → `bus_as_` stays high until the cycle after the grant. `bus_req_` is held low throughout.
- TIMEOUT=4, slave never ready → `c_done`=`c_err`=1 after 4 strobe cycles, bus released. A repeat run with rdy_ on the 4th cycle completes without error.
- Back-to-back `c_req` held high → `bus_req_` high for exactly one cycle between transactions. A second `c_req` pulse while busy produces no extra `c_done`.
- `rst` asserted in ACCESS → next cycle `bus_as_`=1, `bus_req_`=1, `c_busy`=0, no `c_done`.
